// File: rtl/skylark_muldiv.sv
// RV32M multiply/divide unit for the skylark execute stage.
// Iterative restoring divide, single-cycle or shift-add multiply, one registered result per op.
module skylark_muldiv #(
    parameter int unsigned XLEN     = 32,
    parameter bit          FAST_MUL = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_E,
    input  logic [2:0]      func_E,
    input  logic [XLEN-1:0] opA_E,
    input  logic [XLEN-1:0] opB_E,
    input  logic            flush_E,
    output logic            busy,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned     CW       = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state, stateNext;
    logic [CW-1:0]     count, countNext;
    logic [XLEN-1:0]   accHi, accHiNext, accLo, accLoNext;
    logic [XLEN-1:0]   mcand, mcandNext, resultNext;
    logic [1:0]        funcSel, funcSelNext;
    logic              negRes, negResNext, negRem, negRemNext;

    logic              isDiv, aSigned, bSigned, aNeg, bNeg, divZero, divOvf;
    logic [XLEN-1:0]   magA, magB;
    logic [2*XLEN-1:0] fastProd, fastSigned;

    logic [XLEN:0]     mulSum, remShift, trial;
    logic [XLEN-1:0]   mulHiStep, mulLoStep, remStep, quotStep, quotFinal, remFinal;
    logic [2*XLEN-1:0] mulFinal;

    // Operand decode: signedness per funct3, magnitudes and special divide cases
    always_comb begin
        isDiv      = func_E[2];
        aSigned    = isDiv ? ~func_E[0] : (func_E[1:0] != 2'b11);
        bSigned    = isDiv ? ~func_E[0] : ~func_E[1];
        aNeg       = aSigned & opA_E[XLEN-1];
        bNeg       = bSigned & opB_E[XLEN-1];
        magA       = aNeg ? -opA_E : opA_E;
        magB       = bNeg ? -opB_E : opB_E;
        fastProd   = (2*XLEN)'(magA) * (2*XLEN)'(magB);
        fastSigned = (aNeg ^ bNeg) ? -fastProd : fastProd;
        divZero    = (opB_E == '0);
        divOvf     = ~func_E[0] & (opA_E == MOST_NEG) & (opB_E == '1);
    end

    // One iteration step; accHi/accLo hold {hi,lo} product or {remainder,quotient}
    always_comb begin
        mulSum    = {1'b0, accHi} + (accLo[0] ? {1'b0, mcand} : '0);
        mulHiStep = mulSum[XLEN:1];
        mulLoStep = {mulSum[0], accLo[XLEN-1:1]};
        mulFinal  = negRes ? -{mulHiStep, mulLoStep} : {mulHiStep, mulLoStep};

        remShift  = {accHi, accLo[XLEN-1]};
        trial     = remShift - {1'b0, mcand};
        if (!trial[XLEN]) begin
            remStep  = trial[XLEN-1:0];
            quotStep = {accLo[XLEN-2:0], 1'b1};
        end else begin
            remStep  = remShift[XLEN-1:0];
            quotStep = {accLo[XLEN-2:0], 1'b0};
        end
        quotFinal = negRes ? -quotStep : quotStep;
        remFinal  = negRem ? -remStep : remStep;
    end

    always_comb begin
        stateNext   = state;
        countNext   = count;
        accHiNext   = accHi;
        accLoNext   = accLo;
        mcandNext   = mcand;
        funcSelNext = funcSel;
        negResNext  = negRes;
        negRemNext  = negRem;
        resultNext  = result;
        case (state)
            IDLE: begin
                if (start_E && !flush_E) begin
                    funcSelNext = func_E[1:0];
                    negResNext  = aNeg ^ bNeg;
                    negRemNext  = aNeg;
                    countNext   = CW'(XLEN);
                    accHiNext   = '0;
                    if (!isDiv) begin
                        accLoNext = magB;
                        mcandNext = magA;
                        if (FAST_MUL) begin
                            resultNext = (func_E[1:0] == 2'b00) ? fastSigned[XLEN-1:0]
                                                                 : fastSigned[2*XLEN-1:XLEN];
                            stateNext  = DONE;
                        end else begin
                            stateNext = MUL;
                        end
                    end else if (divZero) begin
                        resultNext = func_E[1] ? opA_E : '1;
                        stateNext  = DONE;
                    end else if (divOvf) begin
                        resultNext = func_E[1] ? '0 : opA_E;
                        stateNext  = DONE;
                    end else begin
                        accLoNext = magA;
                        mcandNext = magB;
                        stateNext = DIV;
                    end
                end
            end
            MUL: begin
                if (flush_E) begin
                    stateNext = IDLE;
                end else begin
                    accHiNext = mulHiStep;
                    accLoNext = mulLoStep;
                    countNext = count - CW'(1);
                    if (count == CW'(1)) begin
                        resultNext = (funcSel == 2'b00) ? mulFinal[XLEN-1:0]
                                                        : mulFinal[2*XLEN-1:XLEN];
                        stateNext  = DONE;
                    end
                end
            end
            DIV: begin
                if (flush_E) begin
                    stateNext = IDLE;
                end else begin
                    accHiNext = remStep;
                    accLoNext = quotStep;
                    countNext = count - CW'(1);
                    if (count == CW'(1)) begin
                        resultNext = funcSel[1] ? remFinal : quotFinal;
                        stateNext  = DONE;
                    end
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            accHi   <= '0;
            accLo   <= '0;
            mcand   <= '0;
            funcSel <= '0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            result  <= '0;
        end else begin
            state   <= stateNext;
            count   <= countNext;
            accHi   <= accHiNext;
            accLo   <= accLoNext;
            mcand   <= mcandNext;
            funcSel <= funcSelNext;
            negRes  <= negResNext;
            negRem  <= negRemNext;
            result  <= resultNext;
        end
    end

    // Stall drops in DONE so the pipeline advances together with the result
    assign busy      = (state == MUL) || (state == DIV);
    assign done      = (state == DONE);
    assign stall_req = ((state == IDLE) && start_E && !flush_E) || busy;

endmodule

// File: doc/skylark_muldiv.md
Name: skylark_muldiv

Overview:
Parametrised RV32M multiply/divide unit for the execute stage of the skylark pipeline. It sits beside the ALU and receives the same forwarded operands. While an operation is in flight it requests a stall from the hazard logic. It delivers one registered result, with a single-cycle done pulse, to the execute-path result mux.

Parameters:
XLEN, 32, operand and result width; must be even and at least 8.
FAST_MUL, 1, 1 = multiply completes in 1 cycle (combinational product, registered); 0 = iterative shift-add multiply taking XLEN cycles.

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
start_E  in  1  execute-stage instruction is a mul/div op
func_E  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
opA_E  in  XLEN  rs1 operand (after forwarding)
opB_E  in  XLEN  rs2 operand (after forwarding)
flush_E  in  1  execute-stage flush (branch or jump taken)
busy  out  1  high in MUL or DIV state
stall_req  out  1  stall F/D/E stages
done  out  1  one-cycle pulse; result valid
result  out  XLEN  registered result, held until next completion

Behaviour:
- Clock and reset:
  - Single clock.
  - Reset is asynchronous and active-high. It forces state=IDLE, result=0, done=0, busy=0, stall_req=0 and clears all internal registers.
- State machine states: IDLE, MUL, DIV, DONE.
- IDLE:
  - If start_E=1 and flush_E=0, latch operands, func and sign flags.
  - Multiply with FAST_MUL=1 → DONE, result computed this edge.
  - Multiply with FAST_MUL=0 → MUL, counter=XLEN.
  - Divide with opB=0 → DONE. DIV/DIVU result = all ones; REM/REMU result = opA.
  - DIV/REM with opA=most-negative and opB=−1 → DONE. DIV result = opA; REM result = 0.
  - Any other divide → DIV, counter=XLEN.
- MUL and DIV:
  - Process one bit per cycle and decrement the counter.
  - When counter reaches 1, the next edge applies sign correction and moves to DONE.
  - Divide is restoring division on magnitudes. Quotient is negated if the operand signs differ. Remainder takes the sign of the dividend.
  - Multiply works on a 2·XLEN product of magnitudes and negates the product if signs differ.
  - MUL takes the low XLEN bits; MULH, MULHSU and MULHU take the high XLEN bits. MULHSU treats opA as signed and opB as unsigned; the U variants treat operands as unsigned.
- DONE:
  - done=1 for exactly one cycle; result register holds the value.
  - Always goes to IDLE on the next edge. start_E is ignored in DONE, so the stalled instruction still present does not restart.
- stall_req = (state==IDLE & start_E & ~flush_E) | (state==MUL) | (state==DIV). It is 0 in DONE so the pipeline advances with the result.
- Latency, counted from the start edge (cycle 0):
  - Iterative op: done high in cycle XLEN+1; stall_req high in cycles 0..XLEN.
  - Fast or special-case op: done high in cycle 1; stall_req high in cycle 0 only.
- flush_E in MUL or DIV: return to IDLE on the next edge. No done pulse; result unchanged.
- flush_E in IDLE with start_E=1: the op is not accepted.
- start_E while in MUL or DIV: ignored; the operation in flight is unaffected.
- busy = state ∈ {MUL, DIV}.
- Result holds its last value across IDLE; it updates only on entry to DONE.
- Reset mid-operation: immediate return to IDLE. done is not asserted; result=0.

Test Plan:
- XLEN=32, DIV 100/7 → stall_req high cycles 0..32, done at cycle 33, result=14; REM of −100/7 → 0xFFFFFFFE (−2).
- DIVU 0x1234/0 → done at cycle 1, result=0xFFFFFFFF; REMU 0x1234/0 → result=0x1234.
- DIV 0x80000000/0xFFFFFFFF → result=0x80000000, done cycle 1; REM of same operands → result=0.
- FAST_MUL=1: MUL −2×3 → done cycle 1, result=0xFFFFFFFA; MULH −2×3 → 0xFFFFFFFF; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- FAST_MUL=0, MULHSU 0xFFFFFFFF (−1) × 0xFFFFFFFF → done cycle 33, result=0xFFFFFFFF; start_E held high through DONE → no second operation.
- DIVU 1000/3 with flush_E at cycle 10 → IDLE at cycle 11, no done, result keeps prior value. Assert reset asynchronously at cycle 5 of a DIV → outputs 0 before the next edge.
